// File: rtl/nand_seq_logic_unit_pkg.sv
// Shared definitions for the sequenced NAND logic unit: opcodes, FSM
// states, per-op step counts, NAND operand/destination selects and the
// (op, step) -> micro-step decoder used by the controller.
package nand_seq_logic_unit_pkg;

  localparam logic [2:0] OP_NAND    = 3'd0;
  localparam logic [2:0] OP_NOT     = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [2:0] N_NAND = 3'd1;
  localparam logic [2:0] N_NOT  = 3'd1;
  localparam logic [2:0] N_AND  = 3'd2;
  localparam logic [2:0] N_OR   = 3'd3;
  localparam logic [2:0] N_NOR  = 3'd4;
  localparam logic [2:0] N_XOR  = 3'd4;
  localparam logic [2:0] N_XNOR = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T1, SRC_T2, SRC_T3} src_t;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_T3, DST_Y} dst_t;

  typedef struct packed {
    src_t sx;
    src_t sz;
    dst_t dst;
    logic last;
  } ustep_t;

  function automatic ustep_t mk(src_t x, src_t z, dst_t d, logic l);
    ustep_t u;
    u.sx = x; u.sz = z; u.dst = d; u.last = l;
    return u;
  endfunction

  // Micro-step table: one NAND per step, destination written at the edge.
  function automatic ustep_t step_decode(logic [2:0] op, logic [2:0] step);
    ustep_t u;
    u = mk(SRC_A, SRC_B, DST_Y, 1'b1);
    case (op)
      OP_NAND: u = mk(SRC_A, SRC_B, DST_Y, 1'b1);
      OP_NOT:  u = mk(SRC_A, SRC_A, DST_Y, 1'b1);
      OP_AND:
        case (step)
          3'd0:    u = mk(SRC_A,  SRC_B,  DST_T1, 1'b0);
          default: u = mk(SRC_T1, SRC_T1, DST_Y,  1'b1);
        endcase
      OP_OR, OP_NOR:
        case (step)
          3'd0:    u = mk(SRC_A,  SRC_A,  DST_T1, 1'b0);
          3'd1:    u = mk(SRC_B,  SRC_B,  DST_T2, 1'b0);
          3'd2:    u = (op == OP_OR) ? mk(SRC_T1, SRC_T2, DST_Y,  1'b1)
                                     : mk(SRC_T1, SRC_T2, DST_T3, 1'b0);
          default: u = mk(SRC_T3, SRC_T3, DST_Y, 1'b1);
        endcase
      OP_XOR, OP_XNOR:
        case (step)
          3'd0:    u = mk(SRC_A,  SRC_B,  DST_T1, 1'b0);
          3'd1:    u = mk(SRC_A,  SRC_T1, DST_T2, 1'b0);
          3'd2:    u = mk(SRC_B,  SRC_T1, DST_T3, 1'b0);
          3'd3:    u = (op == OP_XOR) ? mk(SRC_T2, SRC_T3, DST_Y,  1'b1)
                                      : mk(SRC_T2, SRC_T3, DST_T1, 1'b0);
          default: u = mk(SRC_T1, SRC_T1, DST_Y, 1'b1);
        endcase
      default: u = mk(SRC_A, SRC_B, DST_Y, 1'b1);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/nand_seq_logic_unit_nand_stage.sv
// The single shared WIDTH-bit NAND evaluator.
//   i_x, i_z : operands
//   o_y      : ~(i_x & i_z), bitwise
module nand_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = ~(i_x & i_z);
endmodule

// File: rtl/nand_seq_logic_unit.sv
// Sequenced logic unit: NAND/NOT/AND/OR/NOR/XOR/XNOR built from one shared
// NAND stage, one NAND evaluation per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, sampled only in IDLE, with op/a/b
//   op, a, b   : opcode (7 = illegal) and operands
//   busy       : high from the cycle after accept through the done cycle
//   done       : one-cycle completion pulse
//   err, y     : illegal-op flag and result, held until overwritten
module nand_seq_logic_unit
  import nand_seq_logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] y
);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op, r_step;
  logic [WIDTH-1:0] r_a, r_b, r_t1, r_t2, r_t3, r_y;
  logic             r_err;

  ustep_t           w_us;
  logic [WIDTH-1:0] w_x, w_z, w_n;

  assign w_us = step_decode(r_op, r_step);

  function automatic logic [WIDTH-1:0] pick(src_t s, logic [WIDTH-1:0] va,
                                            logic [WIDTH-1:0] vb, logic [WIDTH-1:0] v1,
                                            logic [WIDTH-1:0] v2, logic [WIDTH-1:0] v3);
    case (s)
      SRC_A:   return va;
      SRC_B:   return vb;
      SRC_T1:  return v1;
      SRC_T2:  return v2;
      default: return v3;
    endcase
  endfunction

  assign w_x = pick(w_us.sx, r_a, r_b, r_t1, r_t2, r_t3);
  assign w_z = pick(w_us.sz, r_a, r_b, r_t1, r_t2, r_t3);

  nand_stage #(.WIDTH(WIDTH)) u_nand (
    .i_x (w_x),
    .i_z (w_z),
    .o_y (w_n)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (op == OP_ILLEGAL) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_us.last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_NAND;
      r_step <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_t3   <= '0;
      r_y    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (start) begin
            if (op == OP_ILLEGAL) begin
              r_err <= 1'b1;
              r_y   <= '0;
            end else begin
              r_op   <= op;
              r_a    <= a;
              r_b    <= b;
              r_step <= '0;
            end
          end
        ST_RUN: begin
          case (w_us.dst)
            DST_T1:  r_t1 <= w_n;
            DST_T2:  r_t2 <= w_n;
            DST_T3:  r_t3 <= w_n;
            default: r_y  <= w_n;
          endcase
          // Final step also retires any stale illegal-op flag.
          if (w_us.last) r_err  <= 1'b0;
          else           r_step <= r_step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done = (r_state == ST_DONE);
  assign err  = r_err;
  assign y    = r_y;

endmodule

// File: tb/tb_nand_seq_logic_unit.sv
module tb_nand_seq_logic_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b, y;
  logic         busy, done, err;

  always #5 clk = ~clk;

  nand_seq_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .y(y)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int           t0;
    int           lat;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0:    return ~(x & z);
      3'd1:    return ~x;
      3'd2:    return x & z;
      3'd3:    return x | z;
      3'd4:    return ~(x | z);
      3'd5:    return x ^ z;
      3'd6:    return ~(x ^ z);
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 2;
      3'd2:       return 3;
      3'd3:       return 4;
      3'd4, 3'd5: return 5;
      3'd6:       return 6;
      default:    return 1;
    endcase
  endfunction

  // Scoreboard: every done pops one expected result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (done && prev_done) chk("done_width", 32'd2, 32'd1);
    prev_done <= done;
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("err", 32'(err), 32'(e.err));
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z, input bit noisy);
    exp_t e;
    int   bcnt = 0;
    bit   seen = 0;
    @(negedge clk);
    e.y = model(o, x, z); e.err = (o == 3'd7); e.t0 = cyc; e.lat = lat_of(o);
    q.push_back(e);
    start = 1'b1; op = o; a = x; b = z;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (noisy && !done) begin
        start = 1'b1; op = 3'($urandom_range(7, 0));
        a = W'($urandom); b = W'($urandom);
      end else start = 1'b0;
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (!seen) q.delete();
    chk("busy_cycles", 32'(bcnt), 32'(e.lat));
    start = 1'b0;
    @(negedge clk);
    chk("y_hold", 32'(y), 32'(e.y));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_y",    32'(y),    32'd0);
    // start alongside reset must not be accepted
    start = 1'b1; op = 3'd3; a = 4'b1100; b = 4'b1010;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);

    run_op(3'd3, 4'b1100, 4'b1010, 0);
    run_op(3'd5, 4'b1100, 4'b1010, 0);
    run_op(3'd6, 4'b1100, 4'b1010, 0);
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ol [4];
      ol[0] = 3'd0; ol[1] = 3'd1; ol[2] = 3'd2; ol[3] = 3'd4;
      run_op(ol[k], 4'b1100, 4'b1010, 0);
    end
    run_op(3'd7, 4'b1100, 4'b1010, 0);
    run_op(3'd2, 4'b1100, 4'b1010, 0);
    run_op(3'd3, 4'b1100, 4'b1010, 1);

    // reset in cycle 2 of an XOR aborts without done
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 4'b1100; b = 4'b1010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y",    32'(y),    32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_op(3'd5, 4'b1100, 4'b1010, 0);

    for (int k = 0; k < 12; k++)
      run_op(3'($urandom_range(7, 0)), W'($urandom), W'($urandom), k[0]);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
